// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg -- op/state encodings and pointer-pair decode for dmem_ctrl
// Revision 1.0
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RDI = 2'b10;
  localparam logic [1:0] OP_WRI = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ADDR  = 3'd1;
  localparam state_t S_LATCH = 3'd2;
  localparam state_t S_READ  = 3'd3;
  localparam state_t S_WRITE = 3'd4;
  localparam state_t S_FIN   = 3'd5;
  localparam state_t S_ERR   = 3'd6;

  localparam int PTR_BASE = 26;

  // Bit n of the mask enables memory word PTR_BASE+n; selector 3 has no pair.
  function automatic logic [5:0] ptr_mask(input logic [1:0] sel);
    logic [31:0] words;
    logic [4:0]  lo;
    words = '0;
    lo    = 5'(PTR_BASE) + {2'b00, sel, 1'b0};
    if (sel != 2'd3) begin
      words[lo]        = 1'b1;
      words[lo + 5'd1] = 1'b1;
    end
    return words[PTR_BASE +: 6];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_ctrl -- single-byte load/store bus master for the data memory
// Revision 1.0
// ============================================================================
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req,
  input  logic [1:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    ptr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          done,
  output logic          err,
  output logic          busy,
  output wire  [AW-1:0] addbus,
  output logic [5:0]    point_add,
  output logic          rd_latch,
  output logic          rd,
  output logic          wr,
  inout  wire  [DW-1:0] databus
);

  state_t        state_q, state_d;
  logic [1:0]    op_q;
  logic [1:0]    ptr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  logic w_accept;
  logic w_in_indirect;
  logic w_q_indirect;
  logic w_q_write;
  logic w_ptr_phase;
  logic w_ptr_drive;

  assign w_accept      = (state_q == S_IDLE) && req;
  assign w_in_indirect = (op == OP_RDI) || (op == OP_WRI);
  assign w_q_indirect  = (op_q == OP_RDI) || (op_q == OP_WRI);
  assign w_q_write     = (op_q == OP_WR) || (op_q == OP_WRI);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = (w_in_indirect && (ptr == 2'd3)) ? S_ERR : S_ADDR;
        end
      end
      S_ADDR:  state_d = w_q_write ? S_WRITE : S_LATCH;
      S_LATCH: state_d = S_READ;
      S_READ:  state_d = S_FIN;
      S_WRITE: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // addr_q only follows direct ops so IDLE/FIN keep showing the last direct address.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= OP_RD;
      ptr_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        op_q    <= op;
        ptr_q   <= ptr;
        wdata_q <= wdata;
        if (!w_in_indirect) begin
          addr_q <= addr;
        end
      end
      if (state_q == S_READ) begin
        rdata_q <= databus;
      end
    end
  end

  // The pointer pair owns addbus from address setup until the access strobe ends.
  assign w_ptr_phase = (state_q == S_ADDR) || (state_q == S_LATCH) ||
                       (state_q == S_READ) || (state_q == S_WRITE);
  assign w_ptr_drive = w_q_indirect && w_ptr_phase;

  assign point_add = w_ptr_drive ? ptr_mask(ptr_q) : 6'b000000;
  assign addbus    = w_ptr_drive ? {AW{1'bz}} : addr_q;
  assign databus   = (state_q == S_WRITE) ? wdata_q : {DW{1'bz}};

  assign rd_latch = (state_q == S_LATCH);
  assign rd       = (state_q == S_READ);
  assign wr       = (state_q == S_WRITE);
  assign done     = (state_q == S_FIN);
  assign err      = (state_q == S_ERR);
  assign busy     = (state_q != S_IDLE);
  assign rdata    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// tb_dmem_ctrl -- byte memory with pointer-pair decode around dmem_ctrl,
// expected responses queued at issue and checked by an independent monitor.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        clr, req;
  logic [1:0]  op, ptr;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        done, err, busy, rd_latch, rd, wr;
  logic [5:0]  point_add;
  wire  [15:0] addbus;
  wire  [7:0]  databus;

  always #5 clk = ~clk;

  dmem_ctrl #(.AW(16), .DW(8)) dut (
    .clk(clk), .clr(clr), .req(req), .op(op), .addr(addr), .ptr(ptr),
    .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .addbus(addbus), .point_add(point_add), .rd_latch(rd_latch), .rd(rd),
    .wr(wr), .databus(databus)
  );

  // ---------------- memory + address decoder model ----------------
  logic [7:0]  mem [0:65535];
  logic [15:0] lat_addr;
  logic [15:0] ptr_val;
  logic        pre_we;
  logic [15:0] pre_a;
  logic [7:0]  pre_d;

  always_comb begin
    ptr_val = 16'h0000;
    case (point_add)
      6'b000011: ptr_val = {mem[27], mem[26]};
      6'b001100: ptr_val = {mem[29], mem[28]};
      6'b110000: ptr_val = {mem[31], mem[30]};
      default:   ptr_val = 16'h0000;
    endcase
  end

  assign addbus  = (point_add != 6'b000000) ? ptr_val : 16'hzzzz;
  assign databus = rd ? mem[lat_addr] : 8'hzz;

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (wr) mem[addbus] <= databus;
    if (rd_latch) lat_addr <= addbus;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_err;
    bit          is_rd;
    logic [15:0] a;
    logic [7:0]  d;
    logic [5:0]  pa;
    int          acc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       h;
  logic [7:0] model [int];
  int n_vec = 0, n_err = 0, cyc = 0, n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endfunction

  always @(negedge clk) begin
    if (rd_latch || rd || wr) begin
      if (sbq.size() == 0) fail("stray_strobe");
      else begin
        chk("rd_wr_excl", 32'(rd & wr), 32'd0);
        chk("strobe_kind", 32'({rd_latch | rd, wr}),
            sbq[0].is_err ? 32'd0 : (sbq[0].is_rd ? 32'd2 : 32'd1));
        chk("addbus", 32'(addbus), 32'(sbq[0].a));
        chk("point_add", 32'(point_add), 32'(sbq[0].pa));
        if (wr) chk("wr_data", 32'(databus), 32'(sbq[0].d));
        if (rd) chk("rd_bus", 32'(databus), 32'(sbq[0].d));
      end
    end
    if (done || err) begin
      if (sbq.size() == 0) fail("stray_response");
      else begin
        h = sbq.pop_front();
        chk("resp_kind", 32'({done, err}), h.is_err ? 32'd1 : 32'd2);
        chk("latency", 32'(cyc - h.acc), h.is_err ? 32'd1 : (h.is_rd ? 32'd4 : 32'd3));
        if (h.is_rd && !h.is_err) chk("rdata", 32'(rdata), 32'(h.d));
        if (done) n_done++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_exp(input logic [1:0] o, input logic [15:0] a,
                          input logic [1:0] p, input logic [7:0] d);
    exp_t        e;
    logic [15:0] ea;
    e.is_rd  = (o[0] == 1'b0);
    e.is_err = o[1] && (p == 2'd3);
    e.pa     = 6'b000000;
    ea       = a;
    if (o[1]) begin
      case (p)
        2'd0: begin ea = {model[27], model[26]}; e.pa = 6'b000011; end
        2'd1: begin ea = {model[29], model[28]}; e.pa = 6'b001100; end
        2'd2: begin ea = {model[31], model[30]}; e.pa = 6'b110000; end
        default: ea = a;
      endcase
    end
    e.a   = ea;
    e.d   = d;
    if (!e.is_err && e.is_rd) e.d = model[int'(ea)];
    if (!e.is_err && !e.is_rd) model[int'(ea)] = d;
    e.acc = cyc;
    sbq.push_back(e);
  endtask

  // Drives one request from an idle cycle; returns one cycle after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [15:0] a,
                       input logic [1:0] p, input logic [7:0] d);
    push_exp(o, a, p, d);
    op = o; addr = a; ptr = p; wdata = d; req = 1'b1;
    @(negedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || sbq.size() != 0) && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= 20) begin
      fail("timeout_idle");
      sbq.delete();
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    model[int'(a)] = d;
    @(negedge clk); #1;
    pre_we = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    logic [15:0] chk_list [12];
    clr = 1'b1; req = 1'b0; op = 2'b00; addr = 16'h0; ptr = 2'd0; wdata = 8'h0;
    pre_we = 1'b0; pre_a = 16'h0; pre_d = 8'h0;
    @(negedge clk); #1;

    preload(16'd26, 8'h00); preload(16'd27, 8'h03);   // pair 26/27 -> 0x0300
    preload(16'd28, 8'h40); preload(16'd29, 8'h00);   // pair 28/29 -> 0x0040
    preload(16'd30, 8'h10); preload(16'd31, 8'h03);   // pair 30/31 -> 0x0310
    preload(16'h0040, 8'h3C);
    preload(16'h0300, 8'h77);
    preload(16'h0310, 8'h99);
    for (int i = 0; i < 10; i++) preload(16'h0100 + 16'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 8; i++)  preload(16'h0200 + 16'(i), 8'hC0 + 8'(i));

    // reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_strobes", 32'({rd_latch, rd, wr}), 32'd0);
    chk("rst_point_add", 32'(point_add), 32'd0);
    chk("rst_addbus", 32'(addbus), 32'd0);
    clr = 1'b0;
    @(negedge clk); #1;

    // direct write then read
    issue(2'b01, 16'h0005, 2'd0, 8'hA5); wait_idle();
    issue(2'b00, 16'h0005, 2'd0, 8'h00); wait_idle();

    // indirect reads through each pair, indirect write then read back
    issue(2'b10, 16'h1234, 2'd1, 8'h00); wait_idle();
    issue(2'b10, 16'h1234, 2'd0, 8'h00); wait_idle();
    issue(2'b11, 16'h0000, 2'd2, 8'h5E); wait_idle();
    issue(2'b10, 16'h0000, 2'd2, 8'h00); wait_idle();
    chk("idle_addbus_last_direct", 32'(addbus), 32'h0005);

    // illegal pointer
    issue(2'b11, 16'h0200, 2'd3, 8'h5A);
    chk("err_busy_high", 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk("err_busy_low", 32'(busy), 32'd0);
    wait_idle();

    // req held for 10 cycles: only cycles 0 and 5 find the controller idle
    base = n_done;
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 5) push_exp(2'b00, 16'h0100 + 16'(i), 2'd0, 8'h00);
      req = 1'b1; op = 2'b00; addr = 16'h0100 + 16'(i);
      @(negedge clk); #1;
    end
    req = 1'b0;
    wait_idle();
    chk("busy_reject_count", 32'(n_done - base), 32'd2);

    // reset during LATCH
    issue(2'b00, 16'h0201, 2'd0, 8'h00);
    @(negedge clk); #1;
    chk("in_latch", 32'(rd_latch), 32'd1);
    sbq.delete();
    clr = 1'b1;
    @(negedge clk); #1;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_strobes", 32'({rd_latch, rd, wr, done}), 32'd0);
    chk("clr_rdata", 32'(rdata), 32'd0);
    clr = 1'b0;
    issue(2'b00, 16'h0202, 2'd0, 8'h00); wait_idle();

    // clr and req together: request dropped
    clr = 1'b1; req = 1'b1; op = 2'b00; addr = 16'h0203;
    @(negedge clk); #1;
    clr = 1'b0; req = 1'b0;
    @(negedge clk); #1;
    chk("clr_beats_req", 32'(busy), 32'd0);

    // mixed traffic
    for (int i = 0; i < 200; i++) begin
      issue(2'($urandom_range(0, 3)), 16'h0200 + 16'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      wait_idle();
    end

    // memory contents against the model
    chk_list[0] = 16'h0005; chk_list[1] = 16'h0040;
    chk_list[2] = 16'h0300; chk_list[3] = 16'h0310;
    for (int i = 0; i < 8; i++) chk_list[4 + i] = 16'h0200 + 16'(i);
    for (int i = 0; i < 12; i++)
      chk("mem_final", 32'(mem[chk_list[i]]), 32'(model[int'(chk_list[i])]));
    chk("queue_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
